pc_fetch_ctrl: RTL and testbench



---
 rtl/pc_fetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter sequencer and instruction-fetch handshake.
// Chooses the PC register load value each cycle (PC+4, branch/jump target or
// reset vector). It also runs imem_req/imem_ready and holds back a redirect
// that arrives while a fetch is still outstanding.
// Build option: define FETCH_TIMEOUT_EN to add a fetch watchdog. When
// imem_ready stays low for MAX_WAIT FETCH cycles, the block enters a sticky
// ERR state.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_cur,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        pc_we,
    output logic [31:0] pc_next,
    output logic        if_valid,
    output logic        flush,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HOLD,
        ST_ERR
    } state_e;

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("pc_fetch_ctrl: MAX_WAIT must be in 1..255");
    end

    state_e      state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    logic        redirect;
    logic [31:0] live_tgt;
    logic [31:0] pc_seq;
    logic        wait_expired;

    assign redirect  = br_taken | jmp;
    assign live_tgt  = (br_taken ? br_target : jmp_target) & 32'hFFFF_FFFC;
    assign pc_seq    = pc_cur + 32'd4;
    assign imem_addr = pc_cur;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [8:0] MAX_WAIT_9 = 9'(MAX_WAIT);

    logic [7:0] wait_cnt_q, wait_cnt_d;

    // This cycle is the MAX_WAIT-th consecutive FETCH cycle without imem_ready.
    assign wait_expired = ({1'b0, wait_cnt_q} + 9'd1) >= MAX_WAIT_9;
    assign fetch_err    = (state_q == ST_ERR);

    // Wait counter next value. BOOT and HOLD only ever leave into FETCH, so
    // clearing while in them covers the "clear on entering FETCH" rule.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_BOOT || state_q == ST_HOLD) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_FETCH) begin
            if (imem_ready) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q != '1) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign wait_expired = 1'b0;
    assign fetch_err    = 1'b0;
`endif

    // Next-state, pending-redirect and PC/fetch output decode.
    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_tgt_d   = pend_tgt_q;
        imem_req     = 1'b0;
        pc_we        = 1'b0;
        pc_next      = pc_seq;
        if_valid     = 1'b0;
        flush        = 1'b0;
        case (state_q)
            ST_BOOT: begin
                pc_we   = 1'b1;
                pc_next = RESET_PC;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (redirect || pend_valid_q) begin
                        // Fetched word is wrong-path: drop it and steer the PC.
                        pc_we        = 1'b1;
                        pc_next      = redirect ? live_tgt : pend_tgt_q;
                        flush        = 1'b1;
                        pend_valid_d = 1'b0;
                    end else begin
                        if_valid = 1'b1;
                        if (stall) begin
                            state_d = ST_HOLD;
                        end else begin
                            pc_we = 1'b1;
                        end
                    end
                end else if (wait_expired) begin
                    state_d = ST_ERR;
                end else if (redirect && !pend_valid_q) begin
                    // The oldest redirect wins; later ones are dropped.
                    pend_valid_d = 1'b1;
                    pend_tgt_d   = live_tgt;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_we   = 1'b1;
                    pc_next = live_tgt;
                    flush   = 1'b1;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase
    end

    // State and pending-redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl. It models the PC register itself and
// checks a directed vector table, hand-written corner sequences and random
// traffic against a behavioural model of the fetch rules.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          MW     = 4;

    localparam int M_BOOT  = 0;
    localparam int M_FETCH = 1;
    localparam int M_HOLD  = 2;
    localparam int M_ERR   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_cur;
    logic        stall = 1'b0, br_taken = 1'b0, jmp = 1'b0, imem_ready = 1'b0;
    logic [31:0] br_target = '0, jmp_target = '0;
    logic        imem_req, pc_we, if_valid, flush, fetch_err;
    logic [31:0] imem_addr, pc_next;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    logic [31:0] pc_reg = 32'h1234_5670;
    int          m_mode = M_BOOT;
    logic [31:0] m_pend[$];
    int          m_waits = 0;

    typedef struct {
        logic st; logic br; logic [31:0] bt; logic jp; logic [31:0] jt; logic rdy;
        logic req; logic [31:0] addr; logic we; logic [31:0] nxt; logic ifv; logic fl;
    } row_t;
    row_t tbl[19];

    assign pc_cur = pc_reg;
    always #5 clk = ~clk;

    pc_fetch_ctrl #(.RESET_PC(RST_PC), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
        .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr),
        .pc_we(pc_we), .pc_next(pc_next), .if_valid(if_valid), .flush(flush),
        .fetch_err(fetch_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1: assert reset and check the reset outputs right away.
    task automatic apply_reset();
        rst_n = 1'b0;
        m_mode = M_BOOT;
        m_pend.delete();
        m_waits = 0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_next", pc_next, RST_PC);
        chk("rst_ifv", if_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_err", fetch_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, compare against the model (and the table row if
    // given), then advance the PC register and the model across the edge.
    task automatic step(input logic st, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt, input logic rdy,
                        input bit use_row, input row_t row);
        logic e_req, e_we, e_ifv, e_fl, e_err, redir;
        logic [31:0] e_nxt, tgt;
        int nmode;
        stall = st; br_taken = br; br_target = bt; jmp = jp; jmp_target = jt; imem_ready = rdy;
        redir = br | jp;
        tgt = br ? bt : jt;
        tgt[1:0] = 2'b00;
        e_req = 0; e_we = 0; e_ifv = 0; e_fl = 0; e_err = 0;
        e_nxt = pc_reg + 32'd4;
        nmode = m_mode;
        case (m_mode)
            M_BOOT: begin
                e_we = 1; e_nxt = RST_PC; nmode = M_FETCH; m_waits = 0;
            end
            M_FETCH: begin
                e_req = 1;
                if (rdy) begin
                    m_waits = 0;
                    if (redir || m_pend.size() > 0) begin
                        e_we = 1; e_fl = 1;
                        e_nxt = redir ? tgt : m_pend[0];
                        m_pend.delete();
                    end else if (st) begin
                        e_ifv = 1; nmode = M_HOLD;
                    end else begin
                        e_ifv = 1; e_we = 1;
                    end
                end else begin
                    if (redir) m_pend.push_back(tgt);
                    m_waits++;
`ifdef FETCH_TIMEOUT_EN
                    if (m_waits >= MW) nmode = M_ERR;
`endif
                end
            end
            M_HOLD: begin
                if (redir) begin
                    e_we = 1; e_fl = 1; e_nxt = tgt; nmode = M_FETCH; m_waits = 0;
                end else if (!st) begin
                    e_we = 1; nmode = M_FETCH; m_waits = 0;
                end
            end
            default: e_err = 1;
        endcase
        #3;
        chk("req", imem_req, e_req);
        if (e_req) chk("addr", imem_addr, pc_reg);
        chk("we", pc_we, e_we);
        if (e_we) chk("next", pc_next, e_nxt);
        chk("ifv", if_valid, e_ifv);
        chk("flush", flush, e_fl);
        chk("err", fetch_err, e_err);
        if (use_row) begin
            chk("tbl_req", imem_req, row.req);
            if (row.req) chk("tbl_addr", imem_addr, row.addr);
            chk("tbl_we", pc_we, row.we);
            if (row.we) chk("tbl_next", pc_next, row.nxt);
            chk("tbl_ifv", if_valid, row.ifv);
            chk("tbl_flush", flush, row.fl);
        end
        @(posedge clk);
        #1;
        if (e_we) pc_reg = e_nxt;
        m_mode = nmode;
    endtask

    task automatic idle(input logic rdy, input logic st);
        row_t none;
        none = '{0, 0, '0, 0, '0, 0, 0, '0, 0, '0, 0, 0};
        step(st, 0, '0, 0, '0, rdy, 0, none);
    endtask

    initial begin
        row_t none;
        none = '{0, 0, '0, 0, '0, 0, 0, '0, 0, '0, 0, 0};
        //          st br bt            jp jt            rdy req addr          we nxt           ifv fl
        tbl[0]  = '{0, 0, 32'h0,        0, 32'h0,        1,  0,  32'h0,        1, 32'h0,        0, 0};
        tbl[1]  = '{0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h0,        1, 32'h4,        1, 0};
        tbl[2]  = '{0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h4,        1, 32'h8,        1, 0};
        tbl[3]  = '{0, 1, 32'h40,       0, 32'h0,        0,  1,  32'h8,        0, 32'h0,        0, 0};
        tbl[4]  = '{0, 0, 32'h0,        1, 32'h80,       0,  1,  32'h8,        0, 32'h0,        0, 0};
        tbl[5]  = '{0, 0, 32'h0,        0, 32'h0,        0,  1,  32'h8,        0, 32'h0,        0, 0};
        tbl[6]  = '{0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h8,        1, 32'h40,       0, 1};
        tbl[7]  = '{0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h40,       1, 32'h44,       1, 0};
        tbl[8]  = '{1, 0, 32'h0,        0, 32'h0,        1,  1,  32'h44,       0, 32'h0,        1, 0};
        tbl[9]  = '{1, 0, 32'h0,        0, 32'h0,        0,  0,  32'h0,        0, 32'h0,        0, 0};
        tbl[10] = '{1, 0, 32'h0,        0, 32'h0,        0,  0,  32'h0,        0, 32'h0,        0, 0};
        tbl[11] = '{0, 0, 32'h0,        0, 32'h0,        0,  0,  32'h0,        1, 32'h48,       0, 0};
        tbl[12] = '{1, 0, 32'h0,        0, 32'h0,        1,  1,  32'h48,       0, 32'h0,        1, 0};
        tbl[13] = '{1, 1, 32'h100,      0, 32'h0,        0,  0,  32'h0,        1, 32'h100,      0, 1};
        tbl[14] = '{0, 1, 32'h20,       1, 32'h30,       1,  1,  32'h100,      1, 32'h20,       0, 1};
        tbl[15] = '{0, 0, 32'h0,        1, 32'h23,       1,  1,  32'h20,       1, 32'h20,       0, 1};
        tbl[16] = '{0, 0, 32'h0,        1, 32'hFFFF_FFFE, 1, 1,  32'h20,       1, 32'hFFFF_FFFC, 0, 1};
        tbl[17] = '{0, 0, 32'h0,        0, 32'h0,        1,  1,  32'hFFFF_FFFC, 1, 32'h0,        1, 0};
        tbl[18] = '{0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h0,        1, 32'h4,        1, 0};

        @(posedge clk);
        #1;
        apply_reset();
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].st, tbl[i].br, tbl[i].bt, tbl[i].jp, tbl[i].jt, tbl[i].rdy, 1, tbl[i]);
        end

        // Reset while a redirect is pending: the pending target must be lost.
        step(0, 1, 32'h200, 0, '0, 0, 0, none);
        apply_reset();
        idle(1, 0);
        idle(1, 0);
        chk("post_rst_pc", pc_reg, 32'h4);

        // Ready stuck low.
        for (int i = 0; i < MW; i++) idle(0, 0);
        #1;
`ifdef FETCH_TIMEOUT_EN
        chk("timeout_err", fetch_err, 1);
        chk("timeout_req", imem_req, 0);
        idle(0, 0);
        idle(1, 0);
        chk("err_sticky", fetch_err, 1);
`else
        for (int i = 0; i < 16; i++) idle(0, 0);
        chk("no_timeout_err", fetch_err, 0);
        chk("no_timeout_req", imem_req, 1);
`endif
        apply_reset();
        chk("rst_boot_we", pc_we, 1);

        // Random traffic with periodic resets.
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 59) apply_reset();
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0), $urandom(),
                 ($urandom_range(0, 9) == 0), $urandom(), ($urandom_range(0, 9) < 7), 0, none);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
